// File: rtl/ram_pkg.sv
// Shared types for the byte-banked two-port RAM controller.
// FSM state enums, byte type and the out-of-range fill value.
package ram_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_HI   = 1'b1
  } rd_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_HI   = 1'b1
  } wr_state_t;

  typedef logic [7:0] byte_t;

  localparam byte_t FILL_BYTE = 8'hFF;

endpackage

// File: rtl/ram_bank.sv
// One 8-bit byte bank: synchronous write, registered read.
// RAM_FWD_EN selects write-first on a same-row collision, else read-first.
module ram_bank
  import ram_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int AW   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  byte_t         i_wdata,
  output byte_t         o_rdata
);

  byte_t r_mem [ROWS];
  byte_t r_q;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

`ifdef RAM_FWD_EN
  logic w_hit;
  assign w_hit = i_re && i_we && (i_raddr == i_waddr);

  // Registered read, forwarding the byte being written on a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else if (i_re) r_q <= w_hit ? i_wdata : r_mem[i_raddr];
  end
`else
  // Registered read of the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end
`endif

  assign o_rdata = r_q;

endmodule

// File: rtl/ram_ctrl.sv
// Two-port even/odd byte-banked RAM controller with split unaligned words.
// Build option RAM_FWD_EN: write-first collisions (default read-first).
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 786432
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              rd_word,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  input  logic              wr_req,
  input  logic              wr_word,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ready
);

  localparam int ROWS = DEPTH / 2;
  localparam int BA_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW   = ADDR_W - 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  function automatic logic inr(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIM;
  endfunction

  rd_state_t         r_rs;
  logic              r_rv;
  logic              r_rword;
  logic              r_rodd;
  logic              r_rlo_ok;
  logic              r_rhi_ok;
  logic [RW-1:0]     r_rrow_hi;
  logic [15:0]       r_hold;

  wr_state_t         r_ws;
  byte_t             r_whi;
  logic              r_whi_ok;
  logic [RW-1:0]     r_wrow_hi;

  logic              w_racc;
  logic              w_wacc;
  logic [ADDR_W-1:0] w_ra1;
  logic [ADDR_W-1:0] w_wa1;
  logic [RW-1:0]     w_rrow;
  logic [RW-1:0]     w_wrow;
  logic              w_re_ev;
  logic              w_re_od;
  logic              w_we_ev;
  logic              w_we_od;
  byte_t             w_d_ev;
  byte_t             w_d_od;
  byte_t             w_q_ev;
  byte_t             w_q_od;
  byte_t             w_lo;
  byte_t             w_hi;
  logic [15:0]       w_asm;

  assign w_racc   = rd_req && (r_rs == R_IDLE);
  assign w_wacc   = wr_req && (r_ws == W_IDLE);
  assign w_ra1    = rd_addr + 1'b1;
  assign w_wa1    = wr_addr + 1'b1;
  assign rd_ready = (r_rs == R_IDLE);
  assign wr_ready = (r_ws == W_IDLE);

  // Read port row and lane enables for this cycle.
  always_comb begin
    w_rrow  = rd_addr[ADDR_W-1:1];
    w_re_ev = 1'b0;
    w_re_od = 1'b0;
    if (r_rs == R_HI) begin
      w_rrow  = r_rrow_hi;
      w_re_ev = r_rhi_ok;
    end else if (w_racc) begin
      unique case (1'b1)
        rd_word && !rd_addr[0]: begin
          w_re_ev = inr(rd_addr);
          w_re_od = inr(w_ra1);
        end
        rd_addr[0]: w_re_od = inr(rd_addr);
        default:    w_re_ev = inr(rd_addr);
      endcase
    end
  end

  // Write port row, lane enables and lane data for this cycle.
  always_comb begin
    w_wrow  = wr_addr[ADDR_W-1:1];
    w_we_ev = 1'b0;
    w_we_od = 1'b0;
    w_d_ev  = wr_data[7:0];
    w_d_od  = wr_data[7:0];
    if (r_ws == W_HI) begin
      w_wrow  = r_wrow_hi;
      w_we_ev = r_whi_ok;
      w_d_ev  = r_whi;
    end else if (w_wacc) begin
      unique case (1'b1)
        wr_word && !wr_addr[0]: begin
          w_we_ev = inr(wr_addr);
          w_we_od = inr(w_wa1);
          w_d_od  = wr_data[15:8];
        end
        wr_addr[0]: w_we_od = inr(wr_addr);
        default:    w_we_ev = inr(wr_addr);
      endcase
    end
  end

  // Read FSM plus the per-access flags used to assemble rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs      <= R_IDLE;
      r_rv      <= 1'b0;
      r_rword   <= 1'b0;
      r_rodd    <= 1'b0;
      r_rlo_ok  <= 1'b0;
      r_rhi_ok  <= 1'b0;
      r_rrow_hi <= '0;
      r_hold    <= '0;
    end else begin
      r_rv <= 1'b0;
      if (r_rv) r_hold <= w_asm;
      unique case (r_rs)
        R_IDLE: if (w_racc) begin
          r_rword   <= rd_word;
          r_rodd    <= rd_addr[0];
          r_rlo_ok  <= inr(rd_addr);
          r_rhi_ok  <= inr(w_ra1);
          r_rrow_hi <= w_ra1[ADDR_W-1:1];
          if (rd_word && rd_addr[0]) r_rs <= R_HI;
          else r_rv <= 1'b1;
        end
        R_HI: begin
          r_rs <= R_IDLE;
          r_rv <= 1'b1;
        end
        default: r_rs <= R_IDLE;
      endcase
    end
  end

  // Write FSM; holds the high byte of an unaligned word for W_HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws      <= W_IDLE;
      r_whi     <= '0;
      r_whi_ok  <= 1'b0;
      r_wrow_hi <= '0;
    end else begin
      unique case (r_ws)
        W_IDLE: if (w_wacc && wr_word && wr_addr[0]) begin
          r_ws      <= W_HI;
          r_whi     <= wr_data[15:8];
          r_whi_ok  <= inr(w_wa1);
          r_wrow_hi <= w_wa1[ADDR_W-1:1];
        end
        W_HI:    r_ws <= W_IDLE;
        default: r_ws <= W_IDLE;
      endcase
    end
  end

  ram_bank #(.ROWS(ROWS), .AW(BA_W)) u_even (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_re    (w_re_ev),
    .i_raddr (w_rrow[BA_W-1:0]),
    .i_we    (w_we_ev),
    .i_waddr (w_wrow[BA_W-1:0]),
    .i_wdata (w_d_ev),
    .o_rdata (w_q_ev)
  );

  ram_bank #(.ROWS(ROWS), .AW(BA_W)) u_odd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_re    (w_re_od),
    .i_raddr (w_rrow[BA_W-1:0]),
    .i_we    (w_we_od),
    .i_waddr (w_wrow[BA_W-1:0]),
    .i_wdata (w_d_od),
    .o_rdata (w_q_od)
  );

  // Lane steering and out-of-range fill for the returned word.
  always_comb begin
    w_lo = r_rodd ? w_q_od : w_q_ev;
    w_hi = r_rodd ? w_q_ev : w_q_od;
    if (!r_rlo_ok) w_lo = FILL_BYTE;
    if (!r_rhi_ok) w_hi = FILL_BYTE;
    if (!r_rword)  w_hi = 8'h00;
    w_asm = {w_hi, w_lo};
  end

  assign rd_valid = r_rv;
  assign rd_data  = r_rv ? w_asm : r_hold;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: split words, range fill, wrap,
// collision behaviour and reset in the middle of a split write.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, rd_word, rd_ready, rd_valid;
  logic [19:0] rd_addr;
  logic [15:0] rd_data;
  logic        wr_req, wr_word, wr_ready;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;

  logic        f_rd_req, f_rd_word, f_rd_ready, f_rd_valid;
  logic [19:0] f_rd_addr;
  logic [15:0] f_rd_data;
  logic        f_wr_req, f_wr_word, f_wr_ready;
  logic [19:0] f_wr_addr;
  logic [15:0] f_wr_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_ctrl #(.ADDR_W(20), .DEPTH(786432)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_word(rd_word), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_word(wr_word), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready)
  );

  ram_ctrl #(.ADDR_W(20), .DEPTH(1 << 20)) u_full (
    .clk(clk), .rst_n(rst_n),
    .rd_req(f_rd_req), .rd_word(f_rd_word), .rd_addr(f_rd_addr),
    .rd_ready(f_rd_ready), .rd_valid(f_rd_valid), .rd_data(f_rd_data),
    .wr_req(f_wr_req), .wr_word(f_wr_word), .wr_addr(f_wr_addr),
    .wr_data(f_wr_data), .wr_ready(f_wr_ready)
  );

  typedef struct {
    string       tag;
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Pop and compare each read result, also checking its cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (rd_valid) begin
        if (sb.size() == 0) check("rd_unexp", 32'(rd_valid), 0);
        else begin
          e = sb.pop_front();
          check(e.tag, 32'(rd_data), 32'(e.d));
          check({e.tag, "_lat"}, cyc, e.due);
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check({e.tag, "_miss"}, 32'(rd_valid), 1);
      end
    end
  end

  task automatic push_exp(input string tag, input logic [15:0] d,
                          input int lat);
    exp_t e;
    e.tag = tag;
    e.d   = d;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [19:0] a, input logic w,
                    input logic [15:0] exp, input string tag);
    int n = 0;
    while (!rd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check({tag, "_rdy_to"}, 32'(rd_ready), 1);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_word = w;
    push_exp(tag, exp, (w && a[0]) ? 2 : 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [19:0] a, input logic w,
                    input logic [15:0] d);
    int n = 0;
    while (!wr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("wr_rdy_to", 32'(wr_ready), 1);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_word = w;
    wr_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0;
    if (w && a[0]) begin
      check("wr_busy", 32'(wr_ready), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) check("drain_to", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] a;
    logic        w;
    logic [15:0] d;
    rst_n = 1'b0;
    {rd_req, rd_word, rd_addr} = '0;
    {wr_req, wr_word, wr_addr, wr_data} = '0;
    {f_rd_req, f_rd_word, f_rd_addr} = '0;
    {f_wr_req, f_wr_word, f_wr_addr, f_wr_data} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_rrdy", 32'(rd_ready), 1);
    check("rst_wrdy", 32'(wr_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr(20'h00100, 1'b1, 16'hBEEF);
    rd(20'h00100, 1'b1, 16'hBEEF, "al_word");

    wr(20'h00101, 1'b1, 16'h1234);
    rd(20'h00101, 1'b1, 16'h1234, "un_word");
    check("rd_busy", 32'(rd_ready), 0);
    rd(20'h00102, 1'b0, 16'h0012, "b2b_byte");
    rd(20'h00100, 1'b0, 16'h00EF, "byte_ev");
    rd(20'h00101, 1'b0, 16'h0034, "byte_od");
    drain();

    wr(20'hBFFFF, 1'b0, 16'h003C);
    rd(20'hC0000, 1'b1, 16'hFFFF, "oor_rd");
    wr(20'hC0000, 1'b1, 16'h1234);
    rd(20'hC0000, 1'b1, 16'hFFFF, "oor_wr");
    rd(20'hBFFFF, 1'b1, 16'hFF3C, "oor_split");
    wr(20'hBFFFF, 1'b1, 16'hAB77);
    rd(20'hBFFFF, 1'b0, 16'h0077, "oor_split_wr");
    drain();

    wr(20'h00200, 1'b1, 16'h0055);
    drain();
    wr_req = 1'b1; wr_word = 1'b1;
    wr_addr = 20'h00200; wr_data = 16'h00AA;
    rd_req = 1'b1; rd_word = 1'b1; rd_addr = 20'h00200;
`ifdef RAM_FWD_EN
    push_exp("collide", 16'h00AA, 1);
`else
    push_exp("collide", 16'h0055, 1);
`endif
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    rd(20'h00200, 1'b1, 16'h00AA, "post_col");
    drain();

    for (int i = 0; i < 8; i++) begin
      a = 20'h00400 + 20'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      wr(a, w, d);
      rd(a, w, w ? d : {8'h00, d[7:0]}, "rnd");
    end
    drain();

    wr(20'h00302, 1'b0, 16'h005C);
    drain();
    wr_req = 1'b1; wr_word = 1'b1;
    wr_addr = 20'h00301; wr_data = 16'h7788;
    rd_req = 1'b1; rd_word = 1'b1; rd_addr = 20'h00101;
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rd_valid), 0);
    check("mid_rst_data", 32'(rd_data), 0);
    check("mid_rst_rrdy", 32'(rd_ready), 1);
    check("mid_rst_wrdy", 32'(wr_ready), 1);
    @(negedge clk);
    check("mid_rst_valid2", 32'(rd_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(20'h00301, 1'b0, 16'h0088, "rst_lo");
    rd(20'h00302, 1'b0, 16'h005C, "rst_hi");
    drain();

    f_wr_req = 1'b1; f_wr_word = 1'b1;
    f_wr_addr = 20'hFFFFF; f_wr_data = 16'hA55A;
    @(posedge clk); #1;
    f_wr_req = 1'b0;
    @(posedge clk); #1;
    f_rd_req = 1'b1; f_rd_word = 1'b0; f_rd_addr = 20'h00000;
    @(posedge clk); #1;
    f_rd_req = 1'b0;
    check("wrap_b_valid", 32'(f_rd_valid), 1);
    check("wrap_byte", 32'(f_rd_data), 32'h00A5);
    f_rd_req = 1'b1; f_rd_word = 1'b1; f_rd_addr = 20'hFFFFF;
    @(posedge clk); #1;
    f_rd_req = 1'b0;
    check("wrap_w_early", 32'(f_rd_valid), 0);
    @(posedge clk); #1;
    check("wrap_w_valid", 32'(f_rd_valid), 1);
    check("wrap_word", 32'(f_rd_data), 32'hA55A);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
